id_ex_elastic_stage: RTL

- Parametrised, elastic ID→EX pipeline boundary. Successor to the fixed, always-advancing ID/EX register.
- Carries a control bundle and a data payload between decode and execute under a valid/ready handshake.
- Uses a 2-entry skid buffer, so a stall from execute is absorbed without a combinational ready path back into decode.
- Adds flush (bubble insertion) for branch/jump redirect. Reset yields defined zero values, never X.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_slot.sv | 53 +++++
 rtl/id_ex_elastic_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared ID/EX definitions: control-bit positions, default widths and payload field offsets.
package pipe_pkg;

  localparam int unsigned ID_EX_CTRL_W = 14;
  localparam int unsigned ID_EX_DATA_W = 170;

  // Control bundle bit positions; an all-zero bundle is a bubble.
  localparam int unsigned CTRL_WE         = 0;
  localparam int unsigned CTRL_MEM_ACCESS = 1;
  localparam int unsigned CTRL_MEM_WR     = 2;
  localparam int unsigned CTRL_MEM_RD     = 3;
  localparam int unsigned CTRL_JAL        = 4;
  localparam int unsigned CTRL_IMM_SEL    = 5;
  localparam int unsigned CTRL_OFF_GEN    = 6;
  localparam int unsigned CTRL_BRANCH     = 7;
  localparam int unsigned CTRL_JUMP       = 8;
  localparam int unsigned CTRL_ALU_OP_LO  = 9;
  localparam int unsigned CTRL_ALU_OP_HI  = 13;

  // Payload field LSB offsets; bits 169:168 are spare.
  localparam int unsigned DATA_PC_LO      = 0;
  localparam int unsigned DATA_PC_NEXT_LO = 32;
  localparam int unsigned DATA_D1_LO      = 64;
  localparam int unsigned DATA_D2_LO      = 96;
  localparam int unsigned DATA_IMM_LO     = 128;
  localparam int unsigned DATA_RD_LO      = 160;
  localparam int unsigned DATA_F3_LO      = 165;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid bit, control bundle and payload; clear zeroes ctrl, keeps data.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned DATA_W = ID_EX_DATA_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/id_ex_elastic_stage.sv
// Elastic ID->EX boundary: main slot drives execute, skid slot absorbs one entry during a stall.
module id_ex_elastic_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned DATA_W = ID_EX_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
  logic [DATA_W-1:0] m_data, s_data, m_data_in;
  logic              m_load, m_clear, s_load, s_clear;
  logic              accept, consume, m_free;
  logic              m_valid_d, s_valid_d;
  logic [1:0]        occ_d, occ_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  // Ready comes only from registered skid state, so out_ready never reaches decode combinationally.
  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign consume  = m_valid & out_ready;
  assign m_free   = ~m_valid | consume;

  // The skid entry is older than the input, so it always wins the refill of M.
  assign m_ctrl_in = s_valid ? s_ctrl : in_ctrl;
  assign m_data_in = s_valid ? s_data : in_data;

  always_comb begin
    m_load    = 1'b0;
    m_clear   = 1'b0;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    m_valid_d = m_valid;
    s_valid_d = s_valid;
    if (flush) begin
      m_clear   = 1'b1;
      s_clear   = 1'b1;
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        m_load    = 1'b1;
        m_valid_d = 1'b1;
        s_load    = accept;
        s_clear   = ~accept;
        s_valid_d = accept;
      end else if (accept) begin
        m_load    = 1'b1;
        m_valid_d = 1'b1;
      end else begin
        m_clear   = 1'b1;
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_load    = 1'b1;
      s_valid_d = 1'b1;
    end
  end

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .CLK     (CLK),
    .Reset   (Reset),
    .load_i  (m_load),
    .clear_i (m_clear),
    .ctrl_i  (m_ctrl_in),
    .data_i  (m_data_in),
    .valid_o (m_valid),
    .ctrl_o  (m_ctrl),
    .data_o  (m_data)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .CLK     (CLK),
    .Reset   (Reset),
    .load_i  (s_load),
    .clear_i (s_clear),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (s_valid),
    .ctrl_o  (s_ctrl),
    .data_o  (s_data)
  );

  assign occ_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};

  always_comb begin
    cnt_d = cnt_q;
    if (m_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      occ_q <= 2'd0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = m_valid;
  assign out_ctrl    = m_valid ? m_ctrl : '0;
  assign out_data    = m_data;
  assign occupancy   = occ_q;
  assign stall_count = cnt_q;

endmodule
